// File: rtl/sequencer_pkg.sv
// Shared types and constants for the instruction sequencer.
//   seq_state_e : sequencer FSM states
//   OP_*        : processor command encodings driven on `operation`
package sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    PAUSED    = 2'd2,
    RESETTING = 2'd3
  } seq_state_e;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_EXECUTE = 2'b01;
  localparam logic [1:0] OP_RESET   = 2'b11;

  // Bit width needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instruction_fifo.sv
// Instruction buffer: DEPTH x 32-bit FIFO with synchronous flush.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : empties the buffer (wins over push/pop)
//   push, wdata    : write one word (caller guarantees not full)
//   pop, rdata     : rdata shows the head entry; pop advances it
//   full, empty    : occupancy flags
//   count          : occupancy 0..DEPTH
module instruction_fifo
  import sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [31:0]              wdata,
  input  logic                     pop,
  output logic [31:0]              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: buffers host instructions and issues them to a
// processor one per cycle, with pause, processor-reset and flush control.
// Optional feature macro: SEQ_STEP_EN (adds `step` single-issue while paused).
// Ports:
//   clk, reset              : clock, asynchronous active-low reset
//   inValid/inInstruction   : host offer; accepted when inReady is high
//   inReady                 : buffer can accept (low when full or resetting)
//   resetReq                : pulse; flush buffer, clear count, reset processor
//   pause                   : level; blocks issue
//   step                    : (SEQ_STEP_EN) issue one word while paused
//   operation               : 00 no-op, 01 execute, 11 reset
//   nextInstruction         : issued word, 0 unless operation is 01
//   busy                    : buffer non-empty or processor reset in progress
//   fifoCount               : buffer occupancy
//   issuedCount             : instructions issued since last reset/flush
// All outputs are registered.
module instruction_sequencer
  import sequencer_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned RESET_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inValid,
  input  logic [31:0]             inInstruction,
  output logic                    inReady,
  input  logic                    resetReq,
  input  logic                    pause,
`ifdef SEQ_STEP_EN
  input  logic                    step,
`endif
  output logic [1:0]              operation,
  output logic [31:0]             nextInstruction,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifoCount,
  output logic [31:0]             issuedCount
);

  localparam int unsigned CW = count_width(DEPTH);

  seq_state_e    state_q, state_d;
  logic [3:0]    rst_cnt_q, rst_cnt_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   instr_q, instr_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic [31:0]   issued_q, issued_d;

  logic          push, pop, flush, step_pop;
  logic          fifo_full, fifo_empty;
  logic [31:0]   fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_nxt;

  instruction_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (flush),
    .push  (push),
    .wdata (inInstruction),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef SEQ_STEP_EN
  assign step_pop = (state_q == PAUSED) && step;
`else
  assign step_pop = 1'b0;
`endif

  // Issue decisions are made from the current state and buffer, and the
  // resulting command is registered, so a word pushed at edge N is issued
  // no earlier than edge N+1.
  always_comb begin
    flush = resetReq;
    push  = inValid && ready_q && !fifo_full && !resetReq;
    pop   = !resetReq && !fifo_empty &&
            ((((state_q == IDLE) || (state_q == ISSUE)) && !pause) || step_pop);
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    op_d      = OP_NOP;
    instr_d   = '0;
    issued_d  = issued_q;

    if (resetReq) begin
      state_d   = RESETTING;
      rst_cnt_d = 4'(RESET_CYCLES - 1);
      op_d      = OP_RESET;
      issued_d  = '0;
    end else begin
      case (state_q)
        RESETTING: begin
          if (rst_cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            rst_cnt_d = rst_cnt_q - 4'd1;
            op_d      = OP_RESET;
          end
        end
        PAUSED: begin
          state_d = pause ? PAUSED : IDLE;
        end
        default: begin
          if (pop)        state_d = ISSUE;
          else if (pause) state_d = PAUSED;
          else            state_d = IDLE;
        end
      endcase

      if (pop) begin
        op_d     = OP_EXECUTE;
        instr_d  = fifo_rdata;
        issued_d = issued_q + 32'd1;
      end
    end
  end

  // inReady/busy are registered, so derive them from the post-edge occupancy.
  always_comb begin
    count_nxt = flush ? '0 : (fifo_count + CW'(push) - CW'(pop));
    ready_d   = (state_d != RESETTING) && (count_nxt != CW'(DEPTH));
    busy_d    = (count_nxt != '0) || (state_d == RESETTING);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rst_cnt_q <= '0;
      op_q      <= OP_NOP;
      instr_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      issued_q  <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      op_q      <= op_d;
      instr_q   <= instr_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      issued_q  <= issued_d;
    end
  end

  assign inReady         = ready_q;
  assign operation       = op_q;
  assign nextInstruction = instr_q;
  assign busy            = busy_q;
  assign fifoCount       = fifo_count;
  assign issuedCount     = issued_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed testbench for instruction_sequencer (DEPTH=8, RESET_CYCLES=2).
// Build with +define+SEQ_STEP_EN to include the single-step scenario.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic [31:0] inInstruction = '0;
  logic        inReady;
  logic        resetReq = 1'b0;
  logic        pause = 1'b0;
`ifdef SEQ_STEP_EN
  logic        step = 1'b0;
`endif
  logic [1:0]  operation;
  logic [31:0] nextInstruction;
  logic        busy;
  logic [3:0]  fifoCount;
  logic [31:0] issuedCount;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  instruction_sequencer #(
    .DEPTH        (8),
    .RESET_CYCLES (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .inValid         (inValid),
    .inInstruction   (inInstruction),
    .inReady         (inReady),
    .resetReq        (resetReq),
    .pause           (pause),
`ifdef SEQ_STEP_EN
    .step            (step),
`endif
    .operation       (operation),
    .nextInstruction (nextInstruction),
    .busy            (busy),
    .fifoCount       (fifoCount),
    .issuedCount     (issuedCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs are changed after this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".op"},     32'(operation), 32'h0);
    check({tag, ".instr"},  nextInstruction, 32'h0);
    check({tag, ".ready"},  32'(inReady), 32'h0);
    check({tag, ".busy"},   32'(busy), 32'h0);
    check({tag, ".count"},  32'(fifoCount), 32'h0);
    check({tag, ".issued"}, issuedCount, 32'h0);
  endtask

  task automatic push_word(input logic [31:0] w);
    inValid       = 1'b1;
    inInstruction = w;
    tick();
    inValid       = 1'b0;
  endtask

  logic [31:0] words [8];

  initial begin
    for (int i = 0; i < 8; i++) words[i] = 32'hC0DE_0000 + 32'(i * 17);

    // Reset state, applied before any clock edge.
    #1 reset = 1'b0;
    #2 check_reset_values("rst_async");
    tick();
    tick();
    check_reset_values("rst_held");
    reset = 1'b1;
    check("rel_ready_before", 32'(inReady), 32'h0);
    tick();
    check("rel_ready_after", 32'(inReady), 32'h1);

    // Back-to-back pair: each word issues on the edge after its acceptance.
    inValid = 1'b1; inInstruction = 32'h2008_0005;
    tick();
    check("pair.op0", 32'(operation), 32'h0);
    check("pair.cnt0", 32'(fifoCount), 32'h1);
    inInstruction = 32'h2109_0003;
    tick();
    inValid = 1'b0;
    check("pair.op1", 32'(operation), 32'h1);
    check("pair.w1", nextInstruction, 32'h2008_0005);
    check("pair.cnt1", 32'(fifoCount), 32'h1);
    check("pair.iss1", issuedCount, 32'd1);
    tick();
    check("pair.op2", 32'(operation), 32'h1);
    check("pair.w2", nextInstruction, 32'h2109_0003);
    check("pair.iss2", issuedCount, 32'd2);
    tick();
    check("pair.op3", 32'(operation), 32'h0);
    check("pair.w3", nextInstruction, 32'h0);
    check("pair.busy3", 32'(busy), 32'h0);
    check("pair.iss3", issuedCount, 32'd2);

    // Fill while paused, then drain in order on consecutive cycles.
    pause = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) push_word(words[i]);
    check("fill.cnt", 32'(fifoCount), 32'd8);
    check("fill.ready", 32'(inReady), 32'h0);
    check("fill.op", 32'(operation), 32'h0);
    check("fill.busy", 32'(busy), 32'h1);
    inValid = 1'b1; inInstruction = 32'hDEAD_BEEF;
    tick();
    inValid = 1'b0;
    check("fill.nopush", 32'(fifoCount), 32'd8);
    pause = 1'b0;
    tick();
    check("drain.idle", 32'(operation), 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("drain.op%0d", i), 32'(operation), 32'h1);
      check($sformatf("drain.w%0d", i), nextInstruction, words[i]);
    end
    check("drain.iss", issuedCount, 32'd10);
    check("drain.cnt", 32'(fifoCount), 32'd0);
    tick();
    check("drain.end", 32'(operation), 32'h0);

    // resetReq mid-stream with 5 buffered; push during reset is dropped.
    pause = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) push_word(words[i]);
    check("rr.cnt5", 32'(fifoCount), 32'd5);
    pause = 1'b0;
    tick();
    tick();
    check("rr.issue", 32'(operation), 32'h1);
    check("rr.issw", nextInstruction, words[0]);
    resetReq = 1'b1; inValid = 1'b1; inInstruction = 32'h1234_5678;
    tick();
    resetReq = 1'b0;
    check("rr.op_a", 32'(operation), 32'h3);
    check("rr.cnt", 32'(fifoCount), 32'd0);
    check("rr.iss", issuedCount, 32'd0);
    check("rr.ready", 32'(inReady), 32'h0);
    check("rr.busy", 32'(busy), 32'h1);
    check("rr.instr", nextInstruction, 32'h0);
    tick();
    check("rr.op_b", 32'(operation), 32'h3);
    resetReq = 1'b1;
    tick();
    resetReq = 1'b0;
    check("rr.restart1", 32'(operation), 32'h3);
    tick();
    check("rr.restart2", 32'(operation), 32'h3);
    check("rr.dropped", 32'(fifoCount), 32'd0);
    tick();
    inValid = 1'b0;
    check("rr.done", 32'(operation), 32'h0);
    check("rr.ready_up", 32'(inReady), 32'h1);
    check("rr.busy_dn", 32'(busy), 32'h0);
    check("rr.cnt_after", 32'(fifoCount), 32'd0);
    tick();
    tick();
    check("rr.quiet", 32'(operation), 32'h0);
    push_word(32'hA5A5_0001);
    tick();
    check("rr.new_op", 32'(operation), 32'h1);
    check("rr.new_w", nextInstruction, 32'hA5A5_0001);
    check("rr.new_iss", issuedCount, 32'd1);
    tick();

`ifdef SEQ_STEP_EN
    // Two step pulses while paused with 3 buffered.
    pause = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) push_word(words[i + 3]);
    tick();
    check("step.hold", 32'(operation), 32'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step.op1", 32'(operation), 32'h1);
    check("step.w1", nextInstruction, words[3]);
    tick();
    check("step.gap", 32'(operation), 32'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step.op2", 32'(operation), 32'h1);
    check("step.w2", nextInstruction, words[4]);
    tick();
    tick();
    check("step.after", 32'(operation), 32'h0);
    check("step.cnt", 32'(fifoCount), 32'd1);
    check("step.iss", issuedCount, 32'd3);
    pause = 1'b0;
    tick();
    tick();
    check("step.resume", nextInstruction, words[5]);
    tick();
`endif

    // Asynchronous reset while issuing.
    pause = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) push_word(words[i]);
    pause = 1'b0;
    tick();
    tick();
    check("arst.pre", 32'(operation), 32'h1);
    #2 reset = 1'b0;
    #1 check_reset_values("arst");
    tick();
    reset = 1'b1;
    tick();
    check("arst.ready", 32'(inReady), 32'h1);
    check("arst.op", 32'(operation), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
